// File: rtl/tape_recorder.sv
// Turns the ROM-SAVE MIC pulse train back into a TAP image in SDRAM: pilot/sync detection, bit pairing,
// byte writes with a one-deep holding register, and a length header back-filled when each block ends.
module tape_recorder #(
  parameter logic [24:0] BASE       = 25'h600000,
  parameter logic [19:0] MAX_SIZE   = 20'hFFFFF,
  parameter int          PILOT_MIN  = 256,
  parameter int          TIMEOUT    = 350000,
  parameter int          W_PILOT_LO = 1940,
  parameter int          W_PILOT_HI = 2600,
  parameter int          W_SYNC_HI  = 1000,
  parameter int          W_BIT_THR  = 2565,
  parameter int          W_END_THR  = 4000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        rec_en,
  input  logic        clear,
  input  logic        mic_in,
  output logic [24:0] buff_addr,
  output logic [7:0]  buff_dout,
  output logic        buff_wr,
  input  logic        buff_ack,
  output logic [19:0] tap_size,
  output logic [15:0] blocks,
  output logic        activity,
  output logic        overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(PILOT_MIN + 1);
  localparam logic [17:0]   P_LO    = 18'(W_PILOT_LO);
  localparam logic [17:0]   P_HI    = 18'(W_PILOT_HI);
  localparam logic [17:0]   S_HI    = 18'(W_SYNC_HI);
  localparam logic [18:0]   BIT_THR = 19'(W_BIT_THR);
  localparam logic [18:0]   END_THR = 19'(W_END_THR);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT   = TW'(TIMEOUT);
  localparam logic [PW-1:0] P_MIN   = PW'(PILOT_MIN);
  localparam logic [24:0]   LIMIT   = BASE + {5'd0, MAX_SIZE};

  typedef enum logic [2:0] {S_IDLE, S_PILOT, S_SYNC2, S_DATA, S_FINISH} state_t;
  state_t state;

  logic          mic_q;
  logic [17:0]   wcnt;
  logic [TW-1:0] tcnt;
  logic          mic_edge, tout, is_l, is_p, is_s, bit_val;
  logic [PW-1:0] pcnt;
  logic          half;
  logic [17:0]   h1;
  logic [2:0]    bitcnt;
  logic [6:0]    shreg;
  logic [15:0]   len;
  logic [24:0]   start;
  logic [1:0]    hdr;
  logic [18:0]   pair_sum;
  logic [24:0]   data_addr;

  // wcnt holds the width of the half-period that the current edge terminates
  assign mic_edge  = ce & (mic_in != mic_q);
  assign tout      = ce & ~mic_edge & (tcnt == T_LAST);
  assign is_l      = wcnt >= P_HI;
  assign is_p      = (wcnt >= P_LO) & ~is_l;
  assign is_s      = wcnt < S_HI;
  assign pair_sum  = {1'b0, h1} + {1'b0, wcnt};
  assign bit_val   = pair_sum >= BIT_THR;
  assign data_addr = start + 25'd2 + {9'd0, len};
  assign activity  = (state == S_SYNC2) || (state == S_DATA);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mic_q <= 1'b0;
      wcnt  <= '1;
      tcnt  <= T_SAT;
    end else if (ce) begin
      mic_q <= mic_in;
      if (mic_edge) begin
        wcnt <= 18'd1;
        tcnt <= '0;
      end else begin
        if (wcnt != '1) wcnt <= wcnt + 18'd1;
        if (tcnt != T_SAT) tcnt <= tcnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_IDLE;
      buff_wr   <= 1'b0;
      buff_addr <= '0;
      buff_dout <= '0;
      tap_size  <= '0;
      blocks    <= '0;
      overflow  <= 1'b0;
      pcnt      <= '0;
      half      <= 1'b0;
      h1        <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      len       <= '0;
      start     <= BASE;
      hdr       <= '0;
    end else begin
      if (buff_wr && buff_ack) buff_wr <= 1'b0;
      if (clear) begin
        state    <= S_IDLE;
        tap_size <= '0;
        blocks   <= '0;
        overflow <= 1'b0;
        start    <= BASE;
        len      <= '0;
      end else begin
        case (state)
          S_IDLE: if (mic_edge && rec_en && is_p) begin
            state <= S_PILOT;
            pcnt  <= PW'(1);
          end
          S_PILOT: begin
            if (!rec_en || tout) state <= S_IDLE;
            else if (mic_edge) begin
              if (is_p) begin
                if (pcnt != P_MIN) pcnt <= pcnt + PW'(1);
              end else if (is_s && pcnt >= P_MIN) state <= S_SYNC2;
              else state <= S_IDLE;
            end
          end
          S_SYNC2: begin
            if (!rec_en || tout) state <= S_IDLE;
            else if (mic_edge) begin
              if (is_s) begin
                state  <= S_DATA;
                half   <= 1'b0;
                bitcnt <= '0;
                len    <= '0;
                hdr    <= '0;
              end else state <= S_IDLE;
            end
          end
          S_DATA: begin
            if (!rec_en || tout) state <= S_FINISH;
            else if (mic_edge) begin
              if (is_l || is_p) state <= S_FINISH;
              else if (!half) begin
                h1   <= wcnt;
                half <= 1'b1;
              end else begin
                half <= 1'b0;
                if (pair_sum >= END_THR) state <= S_FINISH;
                else begin
                  shreg  <= {shreg[5:0], bit_val};
                  bitcnt <= bitcnt + 3'd1;
                  // a still-pending write means the single holding register is busy
                  if (bitcnt == 3'd7) begin
                    if (buff_wr || data_addr >= LIMIT) overflow <= 1'b1;
                    else begin
                      buff_wr   <= 1'b1;
                      buff_addr <= data_addr;
                      buff_dout <= {shreg, bit_val};
                      len       <= len + 16'd1;
                    end
                  end
                end
              end
            end
          end
          S_FINISH: if (!buff_wr) begin
            case (hdr)
              2'd0: if (len == 16'd0) state <= S_IDLE;
                    else begin
                      buff_wr   <= 1'b1;
                      buff_addr <= start;
                      buff_dout <= len[7:0];
                      hdr       <= 2'd1;
                    end
              2'd1: begin
                buff_wr   <= 1'b1;
                buff_addr <= start + 25'd1;
                buff_dout <= len[15:8];
                hdr       <= 2'd2;
              end
              default: begin
                tap_size <= tap_size + 20'(len) + 20'd2;
                blocks   <= blocks + 16'd1;
                start    <= start + {9'd0, len} + 25'd2;
                state    <= S_IDLE;
              end
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tape_recorder.sv
// Randomized MIC waveforms against a list-based TAP image model; a monitor pops expected writes at each handshake.
module tb_tape_recorder;

  localparam logic [24:0] BASE      = 25'h600000;
  localparam logic [19:0] MAX_SIZE  = 20'd40;
  localparam int          PILOT_MIN = 8;
  localparam int          TIMEOUT   = 200;
  localparam int          LIMIT     = 32'h600000 + 40;

  logic        clk_sys = 1'b0, reset = 1'b1, ce = 1'b1, rec_en = 1'b0, clear = 1'b0, mic_in = 1'b0;
  logic        buff_ack = 1'b0;
  logic [24:0] buff_addr;
  logic [7:0]  buff_dout;
  logic        buff_wr;
  logic [19:0] tap_size;
  logic [15:0] blocks;
  logic        activity, overflow;

  tape_recorder #(
    .BASE(BASE), .MAX_SIZE(MAX_SIZE), .PILOT_MIN(PILOT_MIN), .TIMEOUT(TIMEOUT),
    .W_PILOT_LO(48), .W_PILOT_HI(65), .W_SYNC_HI(25), .W_BIT_THR(64), .W_END_THR(100)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .rec_en(rec_en), .clear(clear), .mic_in(mic_in),
    .buff_addr(buff_addr), .buff_dout(buff_dout), .buff_wr(buff_wr), .buff_ack(buff_ack),
    .tap_size(tap_size), .blocks(blocks), .activity(activity), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic [24:0] a; logic [7:0] d; } wr_t;
  wr_t  exp_q[$];
  int   n_checks = 0, n_fail = 0;
  bit   gate = 1'b0, hold = 1'b0;
  int   m_start, m_tap, m_blocks;
  bit   m_ovf;
  logic [7:0] blk_d[8];
  int   blk_n;
  logic        mon_pw = 1'b0, mon_ack = 1'b0, mon_bad = 1'b0;
  logic [24:0] mon_a = '0;
  logic [7:0]  mon_d = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk_sys);
    ce = gate ? ($urandom_range(3) != 0) : 1'b1;
  end

  // Ack responder and scoreboard monitor: checks each handshake and that a waiting request never moves
  initial forever begin
    wr_t e;
    @(negedge clk_sys);
    buff_ack = 1'b0;
    if (buff_wr && mon_pw && !mon_ack && (buff_addr !== mon_a || buff_dout !== mon_d)) mon_bad = 1'b1;
    mon_pw = buff_wr; mon_a = buff_addr; mon_d = buff_dout; mon_ack = 1'b0;
    if (buff_wr && !reset && !hold && $urandom_range(2) == 0) begin
      buff_ack = 1'b1;
      mon_ack  = 1'b1;
      chk("wr_stable", int'(mon_bad), 0);
      mon_bad = 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", buff_addr, buff_dout);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", int'(buff_addr), int'(e.a));
        chk("wr_data", int'(buff_dout), int'(e.d));
      end
    end
  end

  initial begin
    #(10 * 99000);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic wait_t(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk_sys);
      if (ce) k++;
    end
  endtask

  task automatic toggle_mic();
    @(negedge clk_sys);
    mic_in = ~mic_in;
  endtask

  task automatic half(input int w);
    wait_t(w);
    toggle_mic();
  endtask

  function automatic int jit(input int base, input int r);
    return base + int'($urandom_range(2 * r)) - r;
  endfunction

  task automatic push_wr(input int a, input int d);
    wr_t e;
    e.a = 25'(a);
    e.d = 8'(d);
    exp_q.push_back(e);
  endtask

  // Image model: byte n lands at start+2+n unless it is refused; refused bytes set overflow
  task automatic model(input int n, input int dlo, input int dhi, input bit commit);
    int len = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= dlo && i <= dhi) m_ovf = 1'b1;
      else if (m_start + 2 + len >= LIMIT) m_ovf = 1'b1;
      else begin
        push_wr(m_start + 2 + len, int'(blk_d[i]));
        len++;
      end
    end
    if (commit && len > 0) begin
      push_wr(m_start, len % 256);
      push_wr(m_start + 1, len / 256);
      m_tap    += len + 2;
      m_blocks += 1;
      m_start  += len + 2;
    end
  endtask

  task automatic model_clear();
    m_start = int'(BASE); m_tap = 0; m_blocks = 0; m_ovf = 1'b0;
  endtask

  task automatic send_block(input int npilot, input int extra, input bit odd, input int rel,
                            input int clr, input bit drop, input int dlo, input int dhi);
    bit stop = 1'b0;
    int w;
    if (npilot >= PILOT_MIN) model((clr >= 0) ? clr : blk_n, dlo, dhi, clr < 0);
    toggle_mic();
    repeat (npilot) half(jit(54, 3));
    half(17);
    half(18);
    for (int i = 0; i < blk_n && !stop; i++) begin
      for (int b = 7; b >= 0 && !stop; b--) begin
        w = blk_d[i][b] ? jit(43, 2) : jit(21, 2);
        half(w);
        if (b == 7 && i == 0 && npilot >= PILOT_MIN) chk("activity_data", int'(activity), 1);
        if (b == 7 && i == rel) hold = 1'b0;
        if (b == 7 && i == clr) begin
          @(negedge clk_sys); clear = 1'b1;
          @(negedge clk_sys); clear = 1'b0;
          model_clear();
          stop = 1'b1;
        end
        if (!stop) half(w);
      end
    end
    if (!stop) begin
      for (int k = 0; k < extra; k++) begin
        w = $urandom_range(1) ? jit(43, 2) : jit(21, 2);
        half(w);
        half(w);
      end
      if (odd) half(jit(21, 2));
    end
    if (drop) begin
      @(negedge clk_sys);
      rec_en = 1'b0;
    end
    wait_t(TIMEOUT + 30);
    @(negedge clk_sys);
    rec_en = 1'b1;
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk_sys);
    repeat (5) @(negedge clk_sys);
    chk("queue_drained", exp_q.size(), 0);
    chk("tap_size", int'(tap_size), m_tap);
    chk("blocks", int'(blocks), m_blocks);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("activity_idle", int'(activity), 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk_sys); clear = 1'b1;
    @(negedge clk_sys); clear = 1'b0;
    model_clear();
    @(negedge clk_sys);
    chk("clear_tap", int'(tap_size), 0);
    chk("clear_blocks", int'(blocks), 0);
    chk("clear_ovf", int'(overflow), 0);
  endtask

  initial begin
    rec_en = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("rst_buff_wr", int'(buff_wr), 0);
    chk("rst_buff_addr", int'(buff_addr), 0);
    chk("rst_buff_dout", int'(buff_dout), 0);
    chk("rst_tap_size", int'(tap_size), 0);
    chk("rst_blocks", int'(blocks), 0);
    chk("rst_activity", int'(activity), 0);
    chk("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    model_clear();

    // three-byte block, then two back-to-back blocks from a fresh image
    blk_d[0] = 8'h00; blk_d[1] = 8'hFF; blk_d[2] = 8'hA5; blk_n = 3;
    send_block(12, 0, 0, -1, -1, 0, -1, -1);
    pulse_clear();
    blk_d[0] = 8'h12; blk_n = 1;
    send_block(10, 0, 0, -1, -1, 0, -1, -1);
    blk_d[0] = 8'h34; blk_d[1] = 8'h56; blk_n = 2;
    send_block(10, 0, 0, -1, -1, 0, -1, -1);

    // pilot one half short of the minimum, then exactly the minimum
    blk_d[0] = 8'h77; blk_n = 1;
    send_block(PILOT_MIN - 1, 0, 0, -1, -1, 0, -1, -1);
    send_block(PILOT_MIN, 0, 0, -1, -1, 0, -1, -1);

    // first data write held back: the second byte finds the register busy
    hold = 1'b1;
    blk_d[0] = 8'hC3; blk_d[1] = 8'h5A; blk_d[2] = 8'h81; blk_d[3] = 8'h3C; blk_n = 4;
    send_block(10, 0, 0, 2, -1, 0, 1, 1);
    hold = 1'b0;
    pulse_clear();

    // random traffic until the small image fills up
    for (int r = 0; r < 14; r++) begin
      gate  = ($urandom_range(1) == 1);
      blk_n = $urandom_range(4);
      for (int i = 0; i < 8; i++) blk_d[i] = 8'($urandom);
      send_block($urandom_range(12, 6), $urandom_range(7), ($urandom_range(1) == 1), -1, -1,
                 ($urandom_range(3) == 0), -1, -1);
    end
    gate = 1'b0;

    // clear in the middle of a block, then a fresh block restarts at BASE
    blk_d[0] = 8'h11; blk_d[1] = 8'h22; blk_d[2] = 8'h33; blk_n = 3;
    send_block(10, 0, 0, -1, 2, 0, -1, -1);
    blk_d[0] = 8'h9E; blk_n = 1;
    send_block(10, 0, 0, -1, -1, 0, -1, -1);

    chk("queue_empty_end", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
